// File: rtl/zb_trace_capture_if.sv
// zb_trace_capture_if: config chain, source buses and trace read port of zb_trace_capture.
// outTimestamp exists only when ZB_TRACE_TIMESTAMP_EN is defined.
interface zb_trace_capture_if #(
  parameter int NUM_SRC = 8,
  parameter int SRC_W   = 4,
  parameter int DEPTH   = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic                     inCfgShiftEn;
  logic                     inCfgData;
  logic                     inCfgUpdate;
  logic                     outCfgData;
  logic [NUM_SRC*SRC_W-1:0] inSrcBus;
  logic [NUM_SRC-1:0]       inSrcValid;
  logic                     inArm;
  logic                     inReadEnable;
  logic [SRC_W-1:0]         outData;
  logic                     outValid;
  logic                     outEmpty;
  logic                     outFull;
  logic [CNT_W-1:0]         outCount;
  logic                     outTriggered;
  logic                     outDone;
`ifdef ZB_TRACE_TIMESTAMP_EN
  logic [7:0]               outTimestamp;
  modport master (output inCfgShiftEn, inCfgData, inCfgUpdate, inSrcBus, inSrcValid, inArm, inReadEnable,
                  input outCfgData, outData, outValid, outEmpty, outFull, outCount, outTriggered, outDone, outTimestamp);
  modport slave  (input inCfgShiftEn, inCfgData, inCfgUpdate, inSrcBus, inSrcValid, inArm, inReadEnable,
                  output outCfgData, outData, outValid, outEmpty, outFull, outCount, outTriggered, outDone, outTimestamp);
`else
  modport master (output inCfgShiftEn, inCfgData, inCfgUpdate, inSrcBus, inSrcValid, inArm, inReadEnable,
                  input outCfgData, outData, outValid, outEmpty, outFull, outCount, outTriggered, outDone);
  modport slave  (input inCfgShiftEn, inCfgData, inCfgUpdate, inSrcBus, inSrcValid, inArm, inReadEnable,
                  output outCfgData, outData, outValid, outEmpty, outFull, outCount, outTriggered, outDone);
`endif
endinterface

// File: rtl/zb_trace_capture.sv
// zb_trace_capture: serially configured source mux feeding a trace buffer (continuous/on-valid/triggered).
// Optional ZB_TRACE_TIMESTAMP_EN stores an 8-bit saturating capture timestamp with each sample.
module zb_trace_capture #(
  parameter int NUM_SRC = 8,
  parameter int SRC_W   = 4,
  parameter int DEPTH   = 16
) (
  input logic               inClock,
  input logic               inReset,
  zb_trace_capture_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CFG_W = SEL_W + 2 + 2 * SRC_W;
`ifdef ZB_TRACE_TIMESTAMP_EN
  localparam int MEM_W = SRC_W + 8;
`else
  localparam int MEM_W = SRC_W;
`endif
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t           state_q;
  logic [CFG_W-1:0] shift_q, cfg_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q, valid_q;
  logic [MEM_W-1:0] data_q, wdata;
  logic [MEM_W-1:0] mem [DEPTH];
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic [SRC_W-1:0] trig_val, trig_mask, src;
  logic             vld, hit, go, wr, rd;
  assign sel       = cfg_q[SEL_W-1:0];
  assign mode      = cfg_q[SEL_W +: 2];
  assign trig_val  = cfg_q[SEL_W+2 +: SRC_W];
  assign trig_mask = cfg_q[SEL_W+2+SRC_W +: SRC_W];
  // Out-of-range selects fall back to source 0 because no loop index matches.
  always_comb begin
    src = bus.inSrcBus[SRC_W-1:0];
    vld = bus.inSrcValid[0];
    for (int k = 1; k < NUM_SRC; k++)
      if (sel == SEL_W'(k)) begin
        src = bus.inSrcBus[k*SRC_W +: SRC_W];
        vld = bus.inSrcValid[k];
      end
  end
  assign hit   = vld && ((src & trig_mask) == (trig_val & trig_mask));
  assign go    = state_q == ARMED && (mode != 2'b10 || hit);
  assign wr    = !bus.inArm && ((state_q == CAPTURE && (mode == 2'b00 || vld)) ||
                                (state_q == ARMED && mode == 2'b10 && hit));
  assign rd    = bus.inReadEnable && cnt_q != '0;
  assign cnt_d = cnt_q + CNT_W'(wr) - CNT_W'(rd);
`ifdef ZB_TRACE_TIMESTAMP_EN
  logic [7:0] ts_q;
  assign wdata            = {state_q == CAPTURE ? ts_q : 8'd0, src};
  assign bus.outTimestamp = data_q[MEM_W-1 -: 8];
`else
  assign wdata = src;
`endif
  always_ff @(posedge inClock)
    if (wr) mem[wptr_q] <= wdata;
  always_ff @(posedge inClock or negedge inReset)
    if (!inReset) begin
      shift_q <= '0;
      cfg_q   <= '0;
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef ZB_TRACE_TIMESTAMP_EN
      ts_q    <= '0;
`endif
    end else begin
      if (bus.inCfgShiftEn) shift_q <= {bus.inCfgData, shift_q[CFG_W-1:1]};
      if (bus.inCfgUpdate && !bus.inCfgShiftEn && (state_q == IDLE || state_q == DONE)) cfg_q <= shift_q;
      valid_q <= rd;
      if (rd) data_q <= mem[rptr_q];
      if (bus.inArm) begin
        state_q <= ARMED;
        wptr_q  <= '0;
        rptr_q  <= '0;
        cnt_q   <= '0;
        trig_q  <= 1'b0;
      end else begin
        if (wr) wptr_q <= wptr_q + PTR_W'(1);
        if (rd) rptr_q <= rptr_q + PTR_W'(1);
        cnt_q <= cnt_d;
        if (go) state_q <= CAPTURE;
        if (go && mode == 2'b10) trig_q <= 1'b1;
        if (state_q == CAPTURE && cnt_d == CNT_W'(DEPTH)) state_q <= DONE;
`ifdef ZB_TRACE_TIMESTAMP_EN
        if (go) ts_q <= '0;
        else if (state_q == CAPTURE && ts_q != 8'hFF) ts_q <= ts_q + 8'd1;
`endif
      end
    end
  assign bus.outCfgData   = shift_q[0];
  assign bus.outData      = data_q[SRC_W-1:0];
  assign bus.outValid     = valid_q;
  assign bus.outEmpty     = cnt_q == '0;
  assign bus.outFull      = cnt_q == CNT_W'(DEPTH);
  assign bus.outCount     = cnt_q;
  assign bus.outTriggered = trig_q;
  assign bus.outDone      = state_q == DONE;
endmodule

// File: tb/tb_zb_trace_capture.sv
// tb_zb_trace_capture: directed scoreboard bench for zb_trace_capture at default parameters.
module tb_zb_trace_capture;
  logic inClock = 1'b0;
  logic inReset = 1'b0;
  int vectors = 0;
  int errors  = 0;
  logic [3:0] q[$];
`ifdef ZB_TRACE_TIMESTAMP_EN
  logic [7:0] qt[$];
`endif
  zb_trace_capture_if #(.NUM_SRC(8), .SRC_W(4), .DEPTH(16)) bus ();
  zb_trace_capture #(.NUM_SRC(8), .SRC_W(4), .DEPTH(16)) dut (.inClock(inClock), .inReset(inReset), .bus(bus));
  always #5 inClock = ~inClock;
  task automatic tick();
    @(posedge inClock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [12:0] cfg(input logic [2:0] sel, input logic [1:0] mode, input logic [3:0] tv, input logic [3:0] tm);
    return {tm, tv, mode, sel};
  endfunction
  task automatic load_cfg(input logic [12:0] v);
    for (int i = 0; i < 13; i++) begin
      bus.inCfgShiftEn = 1'b1;
      bus.inCfgData = v[i];
      tick();
    end
    bus.inCfgShiftEn = 1'b0;
    bus.inCfgUpdate = 1'b1;
    tick();
    bus.inCfgUpdate = 1'b0;
  endtask
  task automatic arm();
    bus.inArm = 1'b1;
    tick();
    bus.inArm = 1'b0;
  endtask
  task automatic drain(input string tag);
    while (q.size() > 0) begin
      bus.inReadEnable = 1'b1;
      tick();
      check({tag, "_valid"}, 32'(bus.outValid), 32'd1);
      check({tag, "_data"}, 32'(bus.outData), 32'(q.pop_front()));
`ifdef ZB_TRACE_TIMESTAMP_EN
      if (qt.size() > 0) check({tag, "_ts"}, 32'(bus.outTimestamp), 32'(qt.pop_front()));
`endif
    end
    bus.inReadEnable = 1'b0;
  endtask
  task automatic do_reset(input string tag);
    inReset = 1'b0;
    #3;
    check({tag, "_count"}, 32'(bus.outCount), 32'd0);
    check({tag, "_empty"}, 32'(bus.outEmpty), 32'd1);
    check({tag, "_done"}, 32'(bus.outDone), 32'd0);
    check({tag, "_trig"}, 32'(bus.outTriggered), 32'd0);
    check({tag, "_cfgout"}, 32'(bus.outCfgData), 32'd0);
    #3;
    inReset = 1'b1;
    tick();
  endtask
  initial begin
    int n;
    logic [12:0] rb;
    logic [3:0] seq;
    bus.inCfgShiftEn = 1'b0;
    bus.inCfgData = 1'b0;
    bus.inCfgUpdate = 1'b0;
    bus.inSrcBus = '0;
    bus.inSrcValid = '0;
    bus.inArm = 1'b0;
    bus.inReadEnable = 1'b0;
    #2;
    check("rst_valid", 32'(bus.outValid), 32'd0);
    check("rst_data", 32'(bus.outData), 32'd0);
    check("rst_full", 32'(bus.outFull), 32'd0);
    do_reset("rst");
    // Continuous capture of source 3 plus config chain readback
    load_cfg(cfg(3'd3, 2'b00, 4'h0, 4'h0));
    rb = '0;
    for (int i = 0; i < 13; i++) begin
      rb[i] = bus.outCfgData;
      bus.inCfgShiftEn = 1'b1;
      bus.inCfgData = 1'b0;
      tick();
    end
    bus.inCfgShiftEn = 1'b0;
    check("cfg_readback", 32'(rb), 32'(cfg(3'd3, 2'b00, 4'h0, 4'h0)));
    bus.inSrcBus = 32'h7694_5210;
    for (int i = 0; i < 16; i++) q.push_back(4'h5);
    arm();
    n = 0;
    while (!bus.outDone && n < 40) begin
      tick();
      n++;
    end
    check("cont_done_cycles", 32'(n), 32'd17);
    check("cont_count", 32'(bus.outCount), 32'd16);
    check("cont_full", 32'(bus.outFull), 32'd1);
    drain("cont");
    check("cont_empty", 32'(bus.outEmpty), 32'd1);
    check("cont_done_held", 32'(bus.outDone), 32'd1);
    // On-valid capture of source 1 with distractor valids on other sources
    load_cfg(cfg(3'd1, 2'b01, 4'h0, 4'h0));
    bus.inSrcValid = '0;
    arm();
    tick();
    for (int v = 1; v <= 4; v++) begin
      bus.inSrcBus[7:4] = 4'(v);
      bus.inSrcValid = 8'b0000_0010;
      q.push_back(4'(v));
      tick();
      bus.inSrcBus[7:4] = 4'hF;
      bus.inSrcValid = 8'b1111_1101;
      tick();
    end
    bus.inSrcValid = '0;
    repeat (20) tick();
    check("ov_count", 32'(bus.outCount), 32'd4);
    check("ov_done", 32'(bus.outDone), 32'd0);
    drain("ov");
    bus.inReadEnable = 1'b1;
    tick();
    bus.inReadEnable = 1'b0;
    check("ov_empty_read_valid", 32'(bus.outValid), 32'd0);
    check("ov_empty_read_hold", 32'(bus.outData), 32'h4);
    // Reset in the middle of a capture at count 7
    for (int i = 0; i < 7; i++) begin
      bus.inSrcBus[7:4] = 4'(i);
      bus.inSrcValid = 8'b0000_0010;
      tick();
    end
    bus.inSrcValid = '0;
    check("mid_count", 32'(bus.outCount), 32'd7);
    do_reset("midrst");
    bus.inSrcValid = 8'hFF;
    repeat (4) tick();
    bus.inSrcValid = '0;
    check("midrst_idle", 32'(bus.outCount), 32'd0);
    arm();
    tick();
    tick();
    check("midrst_cfg_cleared", 32'(bus.outCount), 32'd1);
    do_reset("rst2");
    // Triggered capture on source 2 == 0xA
    load_cfg(cfg(3'd2, 2'b10, 4'hA, 4'hF));
    arm();
    bus.inSrcBus[11:8] = 4'hA;
    bus.inSrcValid = 8'b1111_1011;
    tick();
    check("trig_novalid", 32'(bus.outTriggered), 32'd0);
    bus.inSrcBus[11:8] = 4'h3;
    bus.inSrcValid = 8'b0000_0100;
    tick();
    check("trig_nomatch", 32'(bus.outTriggered), 32'd0);
    check("trig_nomatch_count", 32'(bus.outCount), 32'd0);
    bus.inSrcBus[11:8] = 4'hA;
    q.push_back(4'hA);
    tick();
    check("trig_hit", 32'(bus.outTriggered), 32'd1);
    check("trig_hit_count", 32'(bus.outCount), 32'd1);
    bus.inSrcBus[11:8] = 4'h7;
    q.push_back(4'h7);
    tick();
    bus.inSrcValid = '0;
    tick();
    check("trig_count", 32'(bus.outCount), 32'd2);
    drain("trig");
    // Config update while capturing must not take effect
    load_cfg(cfg(3'd0, 2'b00, 4'h0, 4'h0));
    bus.inSrcBus[3:0] = 4'hC;
    bus.inSrcValid = 8'b1111_1011;
    repeat (3) tick();
    bus.inSrcBus[11:8] = 4'h9;
    bus.inSrcValid = 8'b0000_0100;
    q.push_back(4'h9);
    tick();
    bus.inSrcValid = '0;
    repeat (2) tick();
    check("upd_ignored_count", 32'(bus.outCount), 32'd1);
    check("upd_ignored_trig", 32'(bus.outTriggered), 32'd1);
    drain("upd");
    // Continuous capture with simultaneous reads from count 8
    do_reset("rst3");
    load_cfg(cfg(3'd0, 2'b00, 4'h0, 4'h0));
    arm();
    tick();
    seq = 4'h0;
    for (int i = 0; i < 8; i++) begin
      bus.inSrcBus[3:0] = seq;
      tick();
      q.push_back(seq);
      seq++;
    end
    check("sim_count8", 32'(bus.outCount), 32'd8);
    bus.inReadEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.inSrcBus[3:0] = seq;
      tick();
      q.push_back(seq);
      seq++;
      check("sim_rd_data", 32'(bus.outData), 32'(q.pop_front()));
    end
    bus.inReadEnable = 1'b0;
    check("sim_count_held", 32'(bus.outCount), 32'd8);
    check("sim_no_done", 32'(bus.outDone), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.inSrcBus[3:0] = seq;
      tick();
      q.push_back(seq);
      seq++;
    end
    check("sim_done", 32'(bus.outDone), 32'd1);
    check("sim_count16", 32'(bus.outCount), 32'd16);
    bus.inSrcBus[3:0] = 4'hE;
    repeat (3) tick();
    check("sim_done_nowrite", 32'(bus.outCount), 32'd16);
    drain("sim");
`ifdef ZB_TRACE_TIMESTAMP_EN
    // Timestamps at capture cycles 0, 5 and 300 (saturating)
    do_reset("rst4");
    load_cfg(cfg(3'd0, 2'b01, 4'h0, 4'h0));
    arm();
    tick();
    for (int c = 0; c <= 300; c++) begin
      bus.inSrcValid = (c == 0 || c == 5 || c == 300) ? 8'h01 : 8'h00;
      bus.inSrcBus[3:0] = 4'(c);
      if (c == 0 || c == 5 || c == 300) begin
        q.push_back(4'(c));
        qt.push_back(c > 255 ? 8'd255 : 8'(c));
      end
      tick();
    end
    bus.inSrcValid = '0;
    check("ts_count", 32'(bus.outCount), 32'd3);
    drain("ts");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/zb_trace_capture.md
Name: zb_trace_capture

Overview:
- Parametrised test-access and trace block for the ZigBee TX/RX chain (inFIFO, modulator, decoder, CORDIC, CDR, outFIFO).
- Replaces per-mux select pins with a serially loaded configuration register.
- Selects one of NUM_SRC internal buses and captures its samples into an on-chip trace buffer in continuous, on-valid or triggered mode.
- The buffer is read out through a 4-bit-style FIFO read port.

Parameters:
- NUM_SRC, 8, number of observable source buses (≥2).
- SRC_W, 4, width of each source bus and of a trace sample.
- DEPTH, 16, trace buffer depth in samples (power of 2, ≥4).
- Derived, not overridable: SEL_W = clog2(NUM_SRC); CNT_W = clog2(DEPTH)+1; CFG_W = SEL_W+2+2*SRC_W (13 at defaults).

Ports:
- inClock  in  1  system clock, all logic rising-edge.
- inReset  in  1  asynchronous, active-low reset.
- inCfgShiftEn  in  1  shift config chain one bit this cycle.
- inCfgData  in  1  serial config input, LSB first.
- inCfgUpdate  in  1  copy shift chain into active config.
- outCfgData  out  1  serial config output, shift[0].
- inSrcBus  in  NUM_SRC*SRC_W  source buses; source k occupies [k*SRC_W +: SRC_W].
- inSrcValid  in  NUM_SRC  per-source sample-valid strobe.
- inArm  in  1  start a capture (pulse).
- inReadEnable  in  1  pop one trace sample.
- outData  out  SRC_W  popped sample, registered.
- outValid  out  1  outData valid, one-cycle pulse.
- outEmpty  out  1  trace buffer empty.
- outFull  out  1  trace buffer full.
- outCount  out  CNT_W  samples held.
- outTriggered  out  1  trigger seen in current capture.
- outDone  out  1  capture complete.

Behaviour:
- Reset (inReset=0, async):
  - Shift chain, active config, buffer pointers and state cleared; state IDLE.
  - All outputs 0 except outEmpty=1.
  - Reset mid-capture discards buffer contents.
- Config field layout, LSB→MSB: sel[SEL_W], mode[2], trigVal[SRC_W], trigMask[SRC_W].
  - mode: 00 continuous (every cycle), 01 on-valid (inSrcValid[sel]), 10 triggered, 11 reserved (treated as 01).
- Config shift:
  - inCfgShiftEn=1: shift <= {inCfgData, shift[CFG_W-1:1]}.
  - outCfgData=shift[0], so the chain can be daisy-chained and read back.
- Config update:
  - inCfgUpdate loads active config only in IDLE or DONE, and only if inCfgShiftEn=0 that cycle; otherwise ignored.
  - Active config is frozen during ARMED/CAPTURE.
  - sel ≥ NUM_SRC selects source 0.
- FSM:
  - IDLE: inArm → ARMED; buffer flushed (pointers 0), outTriggered=0.
  - ARMED, mode≠10: → CAPTURE next cycle.
  - ARMED, mode 10: → CAPTURE on the first cycle where inSrcValid[sel]=1 and (src & trigMask)==(trigVal & trigMask). That sample is written as entry 0 and outTriggered=1 (sticky until next arm). trigMask=0 triggers on first valid.
  - CAPTURE: write the selected sample per mode condition (mode 10 writes on valid). When count reaches DEPTH → DONE, outDone=1.
  - DONE: no writes; outDone held. inArm → ARMED (flush, outDone=0).
  - inArm in ARMED/CAPTURE: restart (flush, → ARMED).
- Write latency: a sample present at edge n is in the buffer and counted after edge n.
- Read:
  - inReadEnable with outEmpty=0 pops the oldest sample; outData/outValid are updated at the next edge (1-cycle latency).
  - Read on empty is ignored: outValid=0, outData holds.
  - Reads are legal in any state.
  - Simultaneous read and write in CAPTURE: count unchanged; full is not reached that cycle.
- Pointers wrap modulo DEPTH. outFull = count==DEPTH; outEmpty = count==0.

Optional Feature:
- Macro ZB_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds port outTimestamp out 8.
  - An 8-bit counter clears on entry to CAPTURE and increments every cycle in CAPTURE, saturating at 255.
  - Each entry stores {timestamp, sample}; outTimestamp pops with outData at the same latency.
  - Reset value 0.
- Undefined: no port, no counter, buffer is SRC_W wide.

Test Plan:
- Reset + serial config: shift 13 bits encoding sel=3, mode=00, trigVal=0, trigMask=0, then update. outCfgData replays the bits after 13 more shifts. Arm with src3=0x5 constant → outDone=1 after 1+16 cycles, outCount=16, 16 reads return 0x5 with outValid pulses.
- On-valid mode: sel=1, mode=01; pulse inSrcValid[1] on 4 cycles with values 1,2,3,4, then idle 20 cycles → outCount=4, outDone=0; reads return 1,2,3,4; a 5th read gives outValid=0.
- Triggered mode: sel=2, trigVal=0xA, trigMask=0xF; feed valid 0x3,0xA,0x7 → outTriggered=1 on the 0xA cycle; buffer holds 0xA,0x7; 0x3 is absent.
- Full/simultaneous: mode=00 with a read every cycle from count 8 → count holds 8, no DONE. Stop reading → DONE at 16. Update during CAPTURE is ignored.
- Reset mid-capture at count 7 → outCount=0, outEmpty=1, state IDLE, config cleared.
- With ZB_TRACE_TIMESTAMP_EN: mode=01, valids at capture cycles 0,5,300 → timestamps 0,5,255.
